// File: rtl/pipe_stage_reg_if.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg_if
//   Handshake and payload bundle for one pipeline-stage boundary.
//   master : upstream/downstream environment (drives i_*, observes o_*)
//   slave  : the stage register itself (observes i_*, drives o_*)
//   Signals:
//     i_flush            discard held entries, insert a bubble
//     i_valid / o_ready  upstream handshake
//     i_ctrl/i_rd/i_data/i_dmem   incoming payload
//     o_valid / i_ready  downstream handshake
//     o_ctrl/o_rd/o_data/o_dmem   outgoing payload
//     o_count            entries held (0..2)
// ----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int RD_W   = 5
);
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [CTRL_W-1:0] i_ctrl;
    logic [RD_W-1:0]   i_rd;
    logic [DATA_W-1:0] i_data;
    logic [DATA_W-1:0] i_dmem;
    logic              o_valid;
    logic              i_ready;
    logic [CTRL_W-1:0] o_ctrl;
    logic [RD_W-1:0]   o_rd;
    logic [DATA_W-1:0] o_data;
    logic [DATA_W-1:0] o_dmem;
    logic [1:0]        o_count;

    modport master (
        output i_flush, i_valid, i_ctrl, i_rd, i_data, i_dmem, i_ready,
        input  o_ready, o_valid, o_ctrl, o_rd, o_data, o_dmem, o_count
    );

    modport slave (
        input  i_flush, i_valid, i_ctrl, i_rd, i_data, i_dmem, i_ready,
        output o_ready, o_valid, o_ctrl, o_rd, o_data, o_dmem, o_count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised pipeline-stage register with valid/ready handshake, stall,
//   flush with bubble insertion and an optional 2-entry skid buffer.
//   Ports:
//     i_clk    clock, all state on the rising edge
//     i_reset  synchronous active-high reset (priority over everything)
//     bus      pipe_stage_reg_if.slave (handshake, payload, flush, count)
//   Parameters:
//     DATA_W, CTRL_W, RD_W  payload widths
//     CTRL_BUBBLE           o_ctrl value whenever o_valid=0
//     SKID_EN               1: registered o_ready, 2 entries
//                           0: combinational o_ready, 1 entry
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 8,
    parameter int                RD_W        = 5,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter bit                SKID_EN     = 1'b1
) (
    input logic             i_clk,
    input logic             i_reset,
    pipe_stage_reg_if.slave bus
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] dmem;
    } entry_t;

    // Encoding equals the number of held entries, so o_count is the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    entry_t main_q;
    entry_t skid_q;
    logic   ready_q;

    entry_t in_entry;
    logic   valid_w;
    logic   ready_w;
    logic   in_xfer;
    logic   out_xfer;

    assign in_entry = '{ctrl: bus.i_ctrl, rd: bus.i_rd,
                        data: bus.i_data, dmem: bus.i_dmem};

    assign valid_w  = (state_q != EMPTY);

    // With the skid buffer, ready is a flop so it never combinationally
    // follows i_ready. Without it, a full stage can still accept when the
    // downstream drains in the same cycle.
    assign ready_w  = SKID_EN ? ready_q : (!valid_w || bus.i_ready);

    assign in_xfer  = bus.i_valid && ready_w;
    assign out_xfer = valid_w && bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else if (bus.i_flush) begin
            // Payload of main_q is kept; only validity is dropped. A
            // concurrent input is discarded.
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_q  <= in_entry;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_entry;
                    end else if (in_xfer) begin
                        // Only reachable with SKID_EN=1: the combinational
                        // ready of the single-entry variant is low here.
                        skid_q  <= in_entry;
                        state_q <= FULL;
                        ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_valid = valid_w;
    assign bus.o_ready = ready_w;
    assign bus.o_count = state_q;
    // Bubble mux keeps write-enables in the control bundle from leaking
    // while the stage holds nothing.
    assign bus.o_ctrl  = valid_w ? main_q.ctrl : CTRL_BUBBLE;
    assign bus.o_rd    = main_q.rd;
    assign bus.o_data  = main_q.data;
    assign bus.o_dmem  = main_q.dmem;

    // The single-entry variant never holds two entries.
    a_no_full_without_skid : assert property (
        @(posedge i_clk) disable iff (i_reset) (SKID_EN || state_q != FULL));

    // Registered ready must mirror "not full".
    a_ready_matches_state : assert property (
        @(posedge i_clk) disable iff (i_reset)
        (!SKID_EN || (ready_q == (state_q != FULL))));

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [7:0]  c;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [31:0] m;
    } ent_t;

    localparam logic [7:0] BUB_S = 8'h00;
    localparam logic [7:0] BUB_N = 8'h0F;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8), .RD_W(5)) s_if ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8), .RD_W(5)) n_if ();

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .RD_W(5),
                     .CTRL_BUBBLE(BUB_S), .SKID_EN(1'b1))
        u_skid (.i_clk(clk), .i_reset(rst), .bus(s_if.slave));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .RD_W(5),
                     .CTRL_BUBBLE(BUB_N), .SKID_EN(1'b0))
        u_nosk (.i_clk(clk), .i_reset(rst), .bus(n_if.slave));

    int n_assert = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // ---------------- behavioural model: FIFO of held entries -------------
    ent_t sq[$];
    ent_t nq[$];
    ent_t s_last = '0;
    ent_t n_last = '0;

    function automatic bit s_ready();
        return sq.size() < 2;
    endfunction

    function automatic bit n_ready();
        return (nq.size() == 0) || (n_if.i_ready === 1'b1);
    endfunction

    always @(posedge clk) begin
        ent_t in_e;
        bit   rs, rn;
        rs = s_ready();
        rn = n_ready();
        in_e = '{c: s_if.i_ctrl, rd: s_if.i_rd, d: s_if.i_data, m: s_if.i_dmem};
        if (rst) begin
            sq.delete(); nq.delete();
            s_last = '0; n_last = '0;
        end else if (s_if.i_flush) begin
            sq.delete(); nq.delete();
        end else begin
            if (sq.size() > 0 && s_if.i_ready) void'(sq.pop_front());
            if (s_if.i_valid && rs) sq.push_back(in_e);
            if (nq.size() > 0 && n_if.i_ready) void'(nq.pop_front());
            if (n_if.i_valid && rn) nq.push_back(in_e);
            if (sq.size() > 0) s_last = sq[0];
            if (nq.size() > 0) n_last = nq[0];
        end
    end

    task automatic cmp(input string nm, input logic v, input logic r,
                       input logic [1:0] c, input ent_t got,
                       input bit ev, input bit er, input int ec,
                       input ent_t exp);
        n_assert++;
        if (v !== ev || r !== er || c !== ec[1:0] || got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got v=%0b r=%0b cnt=%0d ent=%h, expected v=%0b r=%0b cnt=%0d ent=%h",
                     nm, $time, v, r, c, got, ev, er, ec, exp);
        end
    endtask

    always @(negedge clk) begin
        ent_t g, e;
        if (cmp_en) begin
            g = '{c: s_if.o_ctrl, rd: s_if.o_rd, d: s_if.o_data, m: s_if.o_dmem};
            e = s_last;
            e.c = (sq.size() > 0) ? sq[0].c : BUB_S;
            cmp("skid_model", s_if.o_valid, s_if.o_ready, s_if.o_count, g,
                sq.size() > 0, s_ready(), sq.size(), e);
            g = '{c: n_if.o_ctrl, rd: n_if.o_rd, d: n_if.o_data, m: n_if.o_dmem};
            e = n_last;
            e.c = (nq.size() > 0) ? nq[0].c : BUB_N;
            cmp("noskid_model", n_if.o_valid, n_if.o_ready, n_if.o_count, g,
                nq.size() > 0, n_ready(), nq.size(), e);
        end
    end

    // ---------------- directed stimulus with literal pins -----------------
    task automatic pin(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit rdy, input bit fl,
                         input logic [7:0] c, input logic [31:0] d);
        s_if.i_valid = v;   n_if.i_valid = v;
        s_if.i_ready = rdy; n_if.i_ready = rdy;
        s_if.i_flush = fl;  n_if.i_flush = fl;
        s_if.i_ctrl  = c;   n_if.i_ctrl  = c;
        s_if.i_rd    = d[4:0];  n_if.i_rd   = d[4:0];
        s_if.i_data  = d;   n_if.i_data  = d;
        s_if.i_dmem  = ~d;  n_if.i_dmem  = ~d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 32'hDEAD_0000);
        tick();
        cmp_en = 1'b1;
        tick();
        pin("rst_valid", 32'(s_if.o_valid), 32'd0);
        pin("rst_data",  s_if.o_data, 32'h0);
        pin("rst_ctrl",  32'(s_if.o_ctrl), 32'h0);
        pin("rst_count", 32'(s_if.o_count), 32'd0);
        pin("rst_ready", 32'(s_if.o_ready), 32'd1);
        pin("rst_ctrl_nosk", 32'(n_if.o_ctrl), 32'h0F);

        // stream 4 entries
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(k + 1), 32'h10 + 32'(k));
            tick();
            pin("stream_data", s_if.o_data, 32'h10 + 32'(k));
            pin("stream_count", 32'(s_if.o_count), 32'd1);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
        tick();
        pin("drain_valid", 32'(s_if.o_valid), 32'd0);
        pin("drain_hold", s_if.o_data, 32'h13);

        // back-pressure into the skid buffer
        drive(1'b1, 1'b0, 1'b0, 8'h21, 32'hAAAA_0001);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h22, 32'hBBBB_0002);
        pin("nosk_stall_ready", 32'(n_if.o_ready), 32'd0);
        pin("skid_ready_one", 32'(s_if.o_ready), 32'd1);
        tick();
        pin("bp_count", 32'(s_if.o_count), 32'd2);
        pin("bp_ready", 32'(s_if.o_ready), 32'd0);
        pin("bp_data", s_if.o_data, 32'hAAAA_0001);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        pin("bp_hold", s_if.o_data, 32'hAAAA_0001);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
        tick();
        pin("bp_b_next", s_if.o_data, 32'hBBBB_0002);
        pin("bp_ready_back", 32'(s_if.o_ready), 32'd1);
        tick();
        pin("bp_empty", 32'(s_if.o_count), 32'd0);

        // simultaneous IN and OUT in ONE
        drive(1'b1, 1'b1, 1'b0, 8'h05, 32'h5);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h06, 32'h6);
        tick();
        pin("inout_data", s_if.o_data, 32'h6);
        pin("inout_count", 32'(s_if.o_count), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
        tick();

        // flush while FULL with a valid input
        drive(1'b1, 1'b0, 1'b0, 8'h41, 32'h31);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h42, 32'h32);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'h77, 32'h77);
        tick();
        pin("flush_valid", 32'(s_if.o_valid), 32'd0);
        pin("flush_count", 32'(s_if.o_count), 32'd0);
        pin("flush_ctrl", 32'(s_if.o_ctrl), 32'h0);
        pin("flush_ready", 32'(s_if.o_ready), 32'd1);
        pin("flush_hold", s_if.o_data, 32'h31);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
        tick();
        pin("flush_no77", 32'(s_if.o_valid), 32'd0);

        // no-skid bubble value and pass-through ctrl
        pin("nosk_idle_ctrl", 32'(n_if.o_ctrl), 32'h0F);
        drive(1'b1, 1'b1, 1'b0, 8'h31, 32'h55);
        tick();
        pin("nosk_ctrl", 32'(n_if.o_ctrl), 32'h31);
        pin("nosk_count", 32'(n_if.o_count), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
        tick();

        // mixed traffic pattern, checked by the model every cycle
        for (int i = 0; i < 64; i++) begin
            drive((i % 3) != 0, ((i % 4) != 1) && ((i % 5) != 2), i == 40,
                  8'(i * 7), 32'h100 + 32'(i));
            tick();
        end

        // reset in the middle of a FULL stall
        drive(1'b1, 1'b0, 1'b0, 8'h51, 32'hE1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h52, 32'hE2);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h53, 32'hE3);
        tick();
        pin("pre_rst_count", 32'(s_if.o_count), 32'd2);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h99, 32'h99);
        tick();
        pin("mrst_valid", 32'(s_if.o_valid), 32'd0);
        pin("mrst_count", 32'(s_if.o_count), 32'd0);
        pin("mrst_ready", 32'(s_if.o_ready), 32'd1);
        pin("mrst_data", s_if.o_data, 32'h0);
        pin("mrst_dmem", s_if.o_dmem, 32'h0);
        pin("mrst_rd", 32'(s_if.o_rd), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
        tick();
        pin("skid_lost", 32'(s_if.o_valid), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register; next-generation replacement for the fixed EXE/MEM boundary register, reusable at any stage boundary.
- Adds a valid/ready handshake, stall (back-pressure), flush with bubble insertion, and an optional 2-entry skid buffer so ready can be registered without losing throughput.
- Carries a generic control bundle, a destination register index, and two data words.

Parameters:
- DATA_W, 32, width of the data and dmem words.
- CTRL_W, 8, width of the control bundle (mem2reg, wmem, wreg, loadsignext, lsb, lsh, byte enables packed by the instantiating stage).
- RD_W, 5, destination register index width.
- CTRL_BUBBLE, {CTRL_W{1'b0}}, value driven on o_ctrl whenever o_valid=0; the EXE/MEM instance sets the byte-enable field to 4'b1111.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered o_ready; 0 = single entry with combinational o_ready.

Ports:
- i_clk  in  1  clock, all state on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  discard all held entries; insert a bubble.
- i_valid  in  1  upstream has a valid entry.
- o_ready  out  1  stage can accept an entry.
- i_ctrl  in  CTRL_W  control bundle.
- i_rd  in  RD_W  destination register.
- i_data  in  DATA_W  ALU result or address.
- i_dmem  in  DATA_W  store data.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts.
- o_ctrl  out  CTRL_W  registered control; CTRL_BUBBLE when o_valid=0.
- o_rd  out  RD_W  registered rd.
- o_data  out  DATA_W  registered data.
- o_dmem  out  DATA_W  registered dmem.
- o_count  out  2  entries held (0..2; max 1 when SKID_EN=0).

Behaviour:
- Reset (i_reset=1 at an edge):
  - o_valid=0, o_ctrl=CTRL_BUBBLE, o_rd=0, o_data=0, o_dmem=0, o_count=0.
  - Skid entry cleared; o_ready=1 (SKID_EN=1).
  - Reset has priority over flush and any transfer; an entry presented during reset is dropped.
- Handshake:
  - Input transfer (IN) = i_valid & o_ready at an edge.
  - Output transfer (OUT) = o_valid & i_ready at an edge.
  - Entries leave in arrival order; none is duplicated or dropped except on flush or reset.
  - While o_valid=1 and i_ready=0, all outputs hold stable.
- Latency: an entry accepted at edge N appears on the outputs after edge N (1 cycle) when the stage was empty or drained at edge N.
- SKID_EN=1 states (o_count):
  - EMPTY(0): o_ready=1. IN -> ONE, main register loaded.
  - ONE(1): o_ready=1.
    - IN & OUT -> ONE, main register reloaded.
    - IN & !OUT -> FULL, skid register loaded.
    - OUT & !IN -> EMPTY.
    - Neither -> hold.
  - FULL(2): o_ready=0. OUT -> ONE, main register <- skid register, o_ready=1 next cycle. !OUT -> hold.
  - o_ready is a flop and equals !(state==FULL); it must not depend combinationally on i_ready.
- SKID_EN=0:
  - o_ready = !o_valid | i_ready (combinational).
  - IN loads the main register; OUT & !IN -> empty. o_count is 0 or 1.
- Flush (i_flush=1, no reset):
  - Next state EMPTY: o_valid=0, o_ctrl=CTRL_BUBBLE, o_count=0, skid entry invalidated, o_ready=1.
  - An IN in the same cycle is dropped.
  - o_rd, o_data and o_dmem hold their previous values.
  - Flush overrides stall.
- Bubble rule: o_ctrl equals CTRL_BUBBLE in every cycle with o_valid=0, so no write-enable can leak.
- All widths pass through unmodified; no arithmetic.

Test Plan:
- Reset then stream: assert i_reset for 2 cycles, then stream 4 entries with i_data=0x10..0x13 and i_ready=1 -> outputs at 0x00 and CTRL_BUBBLE (0) during reset; each entry appears 1 cycle after acceptance; one entry per cycle, o_count=1 steady.
- Back-pressure, SKID_EN=1: i_ready=0, send A=0xAAAA0001 and B=0xBBBB0002 -> o_count=2, o_ready=0, o_data=A held. Raise i_ready -> A then B on consecutive cycles; o_ready returns to 1 the cycle after A leaves.
- Simultaneous IN and OUT in ONE state: o_data=0x5, i_data=0x6, both handshakes active -> next cycle o_data=0x6, o_count stays 1.
- Flush while FULL with i_valid=1 (i_data=0x77) -> next cycle o_valid=0, o_count=0, o_ctrl=CTRL_BUBBLE, o_ready=1; 0x77 never appears on the outputs.
- SKID_EN=0, CTRL_BUBBLE=8'h0F: stall with o_valid=1 -> o_ready=0 in the same cycle. Idle -> o_ctrl=8'h0F; entry with i_ctrl=8'h31 -> o_ctrl=8'h31.
- Reset asserted mid-stall in FULL -> all outputs at their reset values after one edge; the skid content is lost.
